// File: rtl/rgb_pwm_driver.sv
// Double-buffered three-channel PWM driver for the RGB LED.
// A duty word is held in a pending buffer and becomes active only at a period wrap.
module rgb_pwm_driver #(
  parameter int PWM_INTERVAL = 1200,
  parameter int DUTY_W       = 11,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DUTY_W-1:0] duty_r,
  input  logic [DUTY_W-1:0] duty_g,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic              duty_valid,
  output logic              duty_ready,
  output logic              period_start,
  output logic              RGB_R,
  output logic              RGB_G,
  output logic              RGB_B
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_INTERVAL - 1);
  localparam logic              PIN_OFF  = (ACTIVE_LOW != 0);

  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] act_r_q, act_r_d, act_g_q, act_g_d, act_b_q, act_b_d;
  logic [DUTY_W-1:0] pend_r_q, pend_r_d, pend_g_q, pend_g_d, pend_b_q, pend_b_d;
  logic              pend_full_q, pend_full_d;
  logic              rgb_r_q, rgb_r_d, rgb_g_q, rgb_g_d, rgb_b_q, rgb_b_d;
  logic              wrap, xfer, commit;

  assign wrap         = (cnt_q == CNT_LAST);
  assign duty_ready   = !pend_full_q && !rst;
  assign xfer         = duty_valid && duty_ready;
  assign commit       = wrap && pend_full_q;
  assign period_start = (cnt_q == '0) && !rst;

  always_comb begin
    cnt_d       = wrap ? '0 : cnt_q + DUTY_W'(1);
    act_r_d     = act_r_q;
    act_g_d     = act_g_q;
    act_b_d     = act_b_q;
    pend_r_d    = pend_r_q;
    pend_g_d    = pend_g_q;
    pend_b_d    = pend_b_q;
    pend_full_d = pend_full_q;
    // Commit and transfer are mutually exclusive: ready is low whenever pend is full.
    if (commit) begin
      act_r_d     = pend_r_q;
      act_g_d     = pend_g_q;
      act_b_d     = pend_b_q;
      pend_full_d = 1'b0;
    end else if (xfer) begin
      pend_r_d    = duty_r;
      pend_g_d    = duty_g;
      pend_b_d    = duty_b;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    rgb_r_d = (cnt_q < act_r_q) ^ PIN_OFF;
    rgb_g_d = (cnt_q < act_g_q) ^ PIN_OFF;
    rgb_b_d = (cnt_q < act_b_q) ^ PIN_OFF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      act_r_q     <= '0;
      act_g_q     <= '0;
      act_b_q     <= '0;
      pend_r_q    <= '0;
      pend_g_q    <= '0;
      pend_b_q    <= '0;
      pend_full_q <= 1'b0;
      rgb_r_q     <= PIN_OFF;
      rgb_g_q     <= PIN_OFF;
      rgb_b_q     <= PIN_OFF;
    end else begin
      cnt_q       <= cnt_d;
      act_r_q     <= act_r_d;
      act_g_q     <= act_g_d;
      act_b_q     <= act_b_d;
      pend_r_q    <= pend_r_d;
      pend_g_q    <= pend_g_d;
      pend_b_q    <= pend_b_d;
      pend_full_q <= pend_full_d;
      rgb_r_q     <= rgb_r_d;
      rgb_g_q     <= rgb_g_d;
      rgb_b_q     <= rgb_b_d;
    end
  end

  assign RGB_R = rgb_r_q;
  assign RGB_G = rgb_g_q;
  assign RGB_B = rgb_b_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: directed scenarios plus randomized words, checked
// against a period-position model of the LED and the pending/active buffers.
module tb_rgb_pwm_driver;

  localparam int PI = 10;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
  logic          duty_valid = 1'b0;
  logic          duty_ready, period_start, RGB_R, RGB_G, RGB_B;

  rgb_pwm_driver #(.PWM_INTERVAL(PI), .DUTY_W(DW), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .period_start(period_start),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position within the period, the active and pending words.
  int   m_phase;
  int   m_act[3];
  int   m_pend[3];
  bit   m_pend_full;
  logic m_pin[3];
  int   m_commit_cyc;
  int   cyc = 0;
  bit   last_acc;
  int   acc_cyc;
  int   meas_lo[3];
  int   meas_ex[3];
  int   meas_first_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_pins_cycle();
    chk("pin_r", RGB_R, m_pin[0]);
    chk("pin_g", RGB_G, m_pin[1]);
    chk("pin_b", RGB_B, m_pin[2]);
    chk("ready", duty_ready, !m_pend_full);
    chk("period_start", period_start, m_phase == 0);
  endtask

  task automatic model_reset();
    m_phase     = 0;
    m_pend_full = 0;
    for (int i = 0; i < 3; i++) begin
      m_act[i]  = 0;
      m_pend[i] = 0;
      m_pin[i]  = 1'b1;
    end
  endtask

  // One clock: model advances from pre-edge inputs, DUT sampled 1 ns after the edge.
  task automatic tick();
    bit acc_dut, xfer_m, wrap_m;
    int din[3];
    acc_dut = duty_valid && duty_ready;
    xfer_m  = duty_valid && !m_pend_full;
    wrap_m  = (m_phase == PI - 1);
    din[0] = int'(duty_r);
    din[1] = int'(duty_g);
    din[2] = int'(duty_b);
    @(posedge clk);
    #1;
    cyc++;
    // Pin shows the previous cycle's position against that period's duty; on = low.
    for (int i = 0; i < 3; i++) m_pin[i] = (m_phase < m_act[i]) ? 1'b0 : 1'b1;
    if (wrap_m && m_pend_full) begin
      m_act        = m_pend;
      m_pend_full  = 0;
      m_commit_cyc = cyc;
    end else if (xfer_m) begin
      m_pend      = din;
      m_pend_full = 1;
    end
    m_phase  = (m_phase + 1) % PI;
    last_acc = acc_dut;
    if (acc_dut) acc_cyc = cyc;
    chk_pins_cycle();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_r"}, RGB_R, 1'b1);
    chk({tag, "_g"}, RGB_G, 1'b1);
    chk({tag, "_b"}, RGB_B, 1'b1);
    chk({tag, "_ready"}, duty_ready, 1'b0);
    chk({tag, "_ps"}, period_start, 1'b0);
  endtask

  task automatic apply_reset(input int hold);
    rst = 1'b1;
    #1;
    model_reset();
    chk_reset_state("rst_async");
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk_reset_state("rst_hold");
    end
    rst = 1'b0;
    #1;
    chk("rel_ps", period_start, 1'b1);
    chk("rel_ready", duty_ready, 1'b1);
  endtask

  task automatic send(input int r, input int g, input int b);
    int n = 0;
    duty_valid = 1'b1;
    duty_r = DW'(r);
    duty_g = DW'(g);
    duty_b = DW'(b);
    do begin
      tick();
      n++;
    end while (!last_acc && n < 60);
    chk("accept_in_time", last_acc, 1'b1);
    duty_valid = 1'b0;
    duty_r = DW'($urandom);
    duty_g = DW'($urandom);
    duty_b = DW'($urandom);
  endtask

  task automatic wait_commit();
    int n = 0;
    while (m_pend_full && n < 40) begin
      tick();
      n++;
    end
    chk("commit_in_time", m_pend_full, 1'b0);
  endtask

  // Count on-cycles over one full period as seen on the pins.
  task automatic measure();
    int n = 0;
    while (!period_start && n < 40) begin
      tick();
      n++;
    end
    chk("period_start_seen", period_start, 1'b1);
    for (int i = 0; i < 3; i++) begin
      meas_lo[i] = 0;
      meas_ex[i] = (m_act[i] >= PI) ? PI : m_act[i];
    end
    meas_first_r = -1;
    for (int k = 0; k < PI; k++) begin
      tick();
      if (RGB_R === 1'b0) begin
        meas_lo[0]++;
        if (meas_first_r < 0) meas_first_r = k;
      end
      if (RGB_G === 1'b0) meas_lo[1]++;
      if (RGB_B === 1'b0) meas_lo[2]++;
    end
  endtask

  initial begin
    int ps_cnt, lo_cnt, cyc_b, gap;
    int rr, gg, bb;

    // 1. Reset
    #2;
    apply_reset(3);
    ps_cnt = 0;
    lo_cnt = 0;
    for (int k = 0; k < 3 * PI; k++) begin
      tick();
      if (period_start === 1'b1) ps_cnt++;
      if (RGB_R !== 1'b1 || RGB_G !== 1'b1 || RGB_B !== 1'b1) lo_cnt++;
    end
    chk("idle_ps_count", ps_cnt, 3);
    chk("idle_pins_on", lo_cnt, 0);

    // 2. Basic duty
    send(3, 0, 10);
    wait_commit();
    measure();
    chk("basic_r_low", meas_lo[0], 3);
    chk("basic_g_low", meas_lo[1], 0);
    chk("basic_b_low", meas_lo[2], 10);
    chk("basic_r_first", meas_first_r, 0);

    // 3. Back-pressure: A then B back-to-back
    send(2, 4, 8);
    send(6, 1, 9);
    cyc_b = acc_cyc;
    chk("bp_b_after_commit", cyc_b, m_commit_cyc + 1);
    wait_commit();
    chk("bp_b_commit_gap", m_commit_cyc - cyc_b, PI - 1);
    measure();
    chk("bp_b_r_low", meas_lo[0], 6);
    chk("bp_b_g_low", meas_lo[1], 1);
    chk("bp_b_b_low", meas_lo[2], 9);

    // 4. Transfer on the wrap edge
    for (int n = 0; n < 20 && m_phase != PI - 1; n++) tick();
    chk("wrap_phase", m_phase, PI - 1);
    chk("wrap_ready", duty_ready, 1'b1);
    duty_valid = 1'b1;
    duty_r = 4'd5;
    duty_g = 4'd1;
    duty_b = 4'd9;
    tick();
    duty_valid = 1'b0;
    chk("wrap_accepted", last_acc, 1'b1);
    measure();
    chk("wrap_old_r", meas_lo[0], 6);
    measure();
    chk("wrap_new_r", meas_lo[0], 5);

    // 5. Clamp and zero
    send(15, 0, 7);
    wait_commit();
    measure();
    chk("clamp_r_low", meas_lo[0], 10);
    chk("zero_g_low", meas_lo[1], 0);
    measure();
    chk("clamp_r_low2", meas_lo[0], 10);
    chk("zero_g_low2", meas_lo[1], 0);

    // 6. Reset mid-period with a word pending
    send(7, 3, 3);
    wait_commit();
    send(2, 2, 2);
    for (int n = 0; n < 20 && m_phase != 4; n++) tick();
    chk("mid_phase", m_phase, 4);
    chk("mid_pending", duty_ready, 1'b0);
    #2;
    apply_reset(2);
    lo_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (RGB_R !== 1'b1) lo_cnt++;
    end
    chk("post_rst_r_off", lo_cnt, 0);
    send(4, 8, 12);
    wait_commit();
    measure();
    chk("post_rst_r_low", meas_lo[0], 4);
    chk("post_rst_b_low", meas_lo[2], 10);

    // Randomized words with random idle gaps and don't-care data while idle
    for (int w = 0; w < 30; w++) begin
      gap = $urandom_range(0, 12);
      for (int k = 0; k < gap; k++) begin
        duty_r = DW'($urandom);
        duty_g = DW'($urandom);
        duty_b = DW'($urandom);
        tick();
      end
      rr = $urandom_range(0, 15);
      gg = $urandom_range(0, 15);
      bb = $urandom_range(0, 15);
      send(rr, gg, bb);
      if (w % 5 == 4) begin
        wait_commit();
        measure();
        chk("rnd_r_low", meas_lo[0], meas_ex[0]);
        chk("rnd_g_low", meas_lo[1], meas_ex[1]);
        chk("rnd_b_low", meas_lo[2], meas_ex[2]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
